// File: rtl/uart_pkg.sv
// Shared UART types and constants for the TX path and the RX that reuses them.
// Frame levels, state encoding and the baud divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    function automatic int clk_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a requester and the UART transmitter.
// Transfer happens on a clock edge with tx_valid && tx_ready.
interface uart_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: runs 0..CLK_DIV-1 while enabled, pulses bit_done on the last cycle.
// Shared by the TX and RX paths.
module uart_baud_cnt #(
    parameter int CLK_DIV = 434,
    parameter int CNT_W   = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt,
    output logic             bit_done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    assign bit_done = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= bit_done ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 at CLK_FREQ/BAUD_RATE cycles per bit, tx driven from a flop.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    uart_tx_if.slave   tx_if,
    output logic       tx,
    output logic       busy
);

    localparam int CLK_DIV = clk_div(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    uart_state_e      state;
    uart_state_e      state_nx;
    logic [CNT_W-1:0] baud_cnt;
    logic             bit_done;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             tx_nx;
    logic             accept;
    logic             last_bit;

    assign accept   = tx_if.tx_valid && tx_if.tx_ready;
    assign last_bit = (bit_idx == 3'(DATA_BITS - 1));

    uart_baud_cnt #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_baud (
        .clk      (sys_clk),
        .rst_n    (rst_n),
        .enable   (state != IDLE),
        .clear    (state == IDLE),
        .cnt      (baud_cnt),
        .bit_done (bit_done)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            tx        <= IDLE_LEVEL;
        end else begin
            state <= state_nx;
            tx    <= tx_nx;
            if (accept) begin
                shift_reg <= tx_if.tx_data;
            end
            // Wraps 7 -> 0 on the edge that leaves DATA
            if (state == DATA && bit_done) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (accept)   state_nx = START;
            START: if (bit_done) state_nx = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:   if (bit_done && last_bit) state_nx = PARITY;
            PARITY: if (bit_done)             state_nx = STOP;
`else
            DATA:  if (bit_done && last_bit) state_nx = STOP;
`endif
            STOP:  if (bit_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        tx_nx = IDLE_LEVEL;
        unique case (state)
            START:  tx_nx = START_LEVEL;
            DATA:   tx_nx = shift_reg[bit_idx];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_nx = ^shift_reg;
`endif
            STOP:   tx_nx = STOP_LEVEL;
            default: tx_nx = IDLE_LEVEL;
        endcase
    end

    assign tx_if.tx_ready = (state == IDLE);
    assign busy           = ~tx_if.tx_ready;

endmodule
